div3_serializer: RTL and testbench

DIV3_SERIALIZER -- requirements
Module: div3_serializer

---
 rtl/div3_pkg.sv | 11 +
 rtl/div3_serializer.sv | 92 +++++++++
 tb/tb_div3_serializer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/div3_pkg.sv
// div3_pkg: state encoding and default word width for the divide-by-3 serializer.
package div3_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DIV3_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/div3_serializer.sv
// div3_serializer: MSB-first word serializer feeding a divide-by-3 checker.
// Define DIV3_SER_HOLD_EN to add the downstream stall input hold_i.
module div3_serializer
    import div3_pkg::*;
#(
    parameter int WIDTH = DIV3_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
`ifdef DIV3_SER_HOLD_EN
    input  logic             hold_i,
`endif
    output logic             ready_o,
    output logic             x_o,
    output logic             bit_valid_o,
    output logic             first_o,
    output logic             last_o,
    output logic             busy_o
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shift_reg;
    logic             holding;
    logic             stall;
    logic             accept;

`ifdef DIV3_SER_HOLD_EN
    assign stall = hold_i;
`else
    assign stall = 1'b0;
`endif

    // A held word at its LSB has already presented that bit, so it must not take a new word.
    assign ready_o = (state == IDLE) || ((cnt == '0) && !holding);
    assign accept  = valid_i && ready_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            shift_reg   <= '0;
            holding     <= 1'b0;
            x_o         <= 1'b0;
            bit_valid_o <= 1'b0;
            first_o     <= 1'b0;
            last_o      <= 1'b0;
            busy_o      <= 1'b0;
        end else if (accept) begin
            state       <= SHIFT;
            cnt         <= CNT_LAST;
            shift_reg   <= data_i;
            holding     <= 1'b0;
            x_o         <= data_i[WIDTH-1];
            bit_valid_o <= 1'b1;
            first_o     <= 1'b1;
            last_o      <= 1'b0;
            busy_o      <= 1'b1;
        end else if (state == SHIFT && stall) begin
            holding     <= 1'b1;
            x_o         <= 1'b0;
            bit_valid_o <= 1'b0;
            first_o     <= 1'b0;
            last_o      <= 1'b0;
            busy_o      <= 1'b1;
        end else if (state == SHIFT && cnt != '0) begin
            cnt         <= cnt - CNT_ONE;
            shift_reg   <= {shift_reg[WIDTH-2:0], 1'b0};
            holding     <= 1'b0;
            x_o         <= shift_reg[WIDTH-2];
            bit_valid_o <= 1'b1;
            first_o     <= 1'b0;
            last_o      <= (cnt == CNT_ONE);
            busy_o      <= 1'b1;
        end else begin
            state       <= IDLE;
            holding     <= 1'b0;
            x_o         <= 1'b0;
            bit_valid_o <= 1'b0;
            first_o     <= 1'b0;
            last_o      <= 1'b0;
            busy_o      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_div3_serializer.sv
// tb_div3_serializer: checks the serializer against a bit-queue model and a divide-by-3 remainder model.
module tb_div3_serializer;

    localparam int W = 8;

    logic         clk      = 1'b0;
    logic         reset    = 1'b1;
    logic [W-1:0] data_i   = '0;
    logic         valid_i  = 1'b0;
    logic         hold_drv = 1'b0;
    logic         ready_o, x_o, bit_valid_o, first_o, last_o, busy_o;

    always #5 clk = ~clk;

    div3_serializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_i     (data_i),
        .valid_i    (valid_i),
`ifdef DIV3_SER_HOLD_EN
        .hold_i     (hold_drv),
`endif
        .ready_o    (ready_o),
        .x_o        (x_o),
        .bit_valid_o(bit_valid_o),
        .first_o    (first_o),
        .last_o     (last_o),
        .busy_o     (busy_o)
    );

    typedef struct {
        logic b;
        logic f;
        logic l;
    } bit_t;

    typedef struct {
        logic [7:0] word;
        int         pulse;
        logic       exp_div;
    } vec_t;

    bit_t        mq[$];
    logic        held      = 1'b0;
    logic        model_acc = 1'b0;
    logic        div_q[$];
    logic [31:0] stream    = '0;
    vec_t        tbl[8];
    int compared = 0, mismatched = 0, cyc = 0;
    int run_len = 0, max_run = 0, t_first = 0, t_last = 0, rem = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model front entry is the bit on x_o now; a held word shows nothing until released.
    task automatic checkOutput();
        logic exp_v, exp_x, exp_f, exp_l;
        exp_v = (mq.size() > 0) && !held;
        exp_x = 1'b0;
        exp_f = 1'b0;
        exp_l = 1'b0;
        if (exp_v) begin
            exp_x = mq[0].b;
            exp_f = mq[0].f;
            exp_l = mq[0].l;
        end
        cyc++;
        chk("bit_valid", bit_valid_o, exp_v);
        chk("x", x_o, exp_x);
        chk("first", first_o, exp_f);
        chk("last", last_o, exp_l);
        chk("ready", ready_o, (mq.size() <= 1) && !held);
        chk("busy", busy_o, mq.size() > 0);
        if (bit_valid_o === 1'b1) begin
            rem    = first_o ? int'(x_o) : (2 * rem + int'(x_o)) % 3;
            stream = {stream[30:0], x_o};
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (first_o) t_first = cyc;
            if (last_o) begin
                t_last = cyc;
                div_q.push_back(rem == 0);
            end
        end else begin
            run_len = 0;
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic h);
        logic hold_eff;
        valid_i = v;
        data_i  = d;
`ifdef DIV3_SER_HOLD_EN
        hold_drv = h;
`else
        hold_drv = 1'b0;
        if (h) hold_drv = 1'b0;
`endif
        hold_eff  = hold_drv;
        model_acc = v && (mq.size() <= 1) && !held;
        if (model_acc) begin
            mq.delete();
            for (int i = 7; i >= 0; i--) mq.push_back('{d[i], i == 7, i == 0});
            held = 1'b0;
        end else if (mq.size() > 0 && hold_eff) begin
            held = 1'b1;
        end else begin
            if (mq.size() > 0) void'(mq.pop_front());
            held = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic doReset(input logic v);
        reset    = 1'b1;
        valid_i  = v;
        data_i   = 8'hAA;
        hold_drv = 1'b0;
        mq.delete();
        held = 1'b0;
        @(negedge clk);
        reset   = 1'b0;
        valid_i = 1'b0;
    endtask

    task automatic sendWord(input logic [7:0] d, input int pulse);
        checkOutput();
        applyStimulus(1'b1, d, 1'b0);
        for (int i = 1; i <= W + 1; i++) begin
            checkOutput();
            if (i == pulse) applyStimulus(1'b1, 8'h55, 1'b0);
            else applyStimulus(1'b0, 8'($urandom), 1'b0);
        end
    endtask

    task automatic sendPair(input logic [7:0] a, input logic [7:0] b);
        int t;
        max_run = 0;
        checkOutput();
        applyStimulus(1'b1, a, 1'b0);
        t = 0;
        do begin
            checkOutput();
            applyStimulus(1'b1, b, 1'b0);
            t++;
        end while (!model_acc && t < 20);
        for (int i = 0; i < W + 1; i++) begin
            checkOutput();
            applyStimulus(1'b0, 8'($urandom), 1'b0);
        end
    endtask

    initial begin
        tbl[0] = '{8'hA5, 3, 1'b1};
        tbl[1] = '{8'h0F, 0, 1'b1};
        tbl[2] = '{8'h10, 0, 1'b0};
        tbl[3] = '{8'h81, 0, 1'b1};
        tbl[4] = '{8'h00, 0, 1'b1};
        tbl[5] = '{8'hFF, 2, 1'b1};
        tbl[6] = '{8'h7F, 0, 1'b0};
        tbl[7] = '{8'h55, 5, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_x", x_o, 1'b0);
        chk("reset_bit_valid", bit_valid_o, 1'b0);
        chk("reset_first", first_o, 1'b0);
        chk("reset_last", last_o, 1'b0);
        chk("reset_busy", busy_o, 1'b0);
        reset = 1'b0;
        chk("reset_ready", ready_o, 1'b1);

        foreach (tbl[i]) begin
            div_q.delete();
            sendWord(tbl[i].word, tbl[i].pulse);
            chk("word_bits", stream[7:0], tbl[i].word);
            chk("div3_count", div_q.size(), 1);
            if (div_q.size() > 0) chk("div3_result", div_q[0], tbl[i].exp_div);
        end

        sendPair(8'h03, 8'hFF);
        chk("b2b_run", max_run, 16);
        chk("b2b_bits", stream[15:0], 16'h03FF);

        div_q.delete();
        sendPair(8'h0F, 8'h10);
        chk("int_count", div_q.size(), 2);
        if (div_q.size() == 2) begin
            chk("int_div_15", div_q[0], 1'b1);
            chk("int_div_16", div_q[1], 1'b0);
        end

        // Reset while bit 4 of F0 is on the wire, then a clean word.
        checkOutput();
        applyStimulus(1'b1, 8'hF0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            checkOutput();
            if (i < 4) applyStimulus(1'b0, 8'h00, 1'b0);
        end
        doReset(1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput();
            applyStimulus(1'b0, 8'h00, 1'b0);
        end
        sendWord(8'h81, 0);
        chk("post_reset_bits", stream[7:0], 8'h81);

        doReset(1'b1);
        for (int i = 0; i < 3; i++) begin
            checkOutput();
            applyStimulus(1'b0, 8'h00, 1'b0);
        end

`ifdef DIV3_SER_HOLD_EN
        checkOutput();
        applyStimulus(1'b1, 8'hC3, 1'b0);
        checkOutput();
        applyStimulus(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput();
            applyStimulus(1'b0, 8'h00, 1'b1);
        end
        for (int i = 0; i < W; i++) begin
            checkOutput();
            applyStimulus(1'b0, 8'h00, 1'b0);
        end
        chk("hold_bits", stream[7:0], 8'hC3);
        chk("hold_span", t_last - t_first + 1, 11);
`endif

        for (int i = 0; i < 400; i++) begin
            checkOutput();
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) == 0);
        end
        for (int i = 0; i < 14; i++) begin
            checkOutput();
            applyStimulus(1'b0, 8'h00, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1, "[TB] timeout");
    end

endmodule
